ise_image_sorter: RTL and testbench
===================================

// Module: ise_image_sorter
// PURPOSE
//  Image Sorting Engine: receives IMAGE_NUM RGB images, one 24-bit pixel per accepted cycle.
//  Classifies each image as red/green/blue dominant and computes its dominant-colour intensity.
//  After the last image, emits all images sorted by (colour, intensity, index), one per cycle.
//  Top-level compute block behind a busy-gated pixel streamer.
// PARAMETERS
//  IMAGE_NUM   32     images per run; image_in_index width = 5
//  IMG_PIXELS  16384  pixels per image (128x128)
// PORTS
//  clk              in   1   single clock, rising edge
//  reset            in   1   asynchronous, active-high
//  image_in_index   in   5   index of image the current pixel belongs to
//  pixel_in         in   24  R=[23:16] G=[15:8] B=[7:0]
//  busy             out  1   registered; 1 = pixel_in not sampled this edge, source holds data
//  out_valid        out  1   result strobe, one cycle per sorted entry
//  color_index      out  2   0=red 1=green 2=blue (3 never driven)
//  image_out_index  out  5   image index of the current sorted entry
// BEHAVIOUR
//  - Reset (async): busy=0, out_valid=0, color_index=0, image_out_index=0; all counters/sums cleared.
//  - Input handshake: at each posedge, pixel/index sampled iff registered busy==0.
//    Data is valid from the first edge after reset release. Busy rising on edge t => no sample at t+1.
//  - Images arrive contiguously: IMG_PIXELS pixels share one image_in_index; order of indices arbitrary.
//  - Pixel class: R>=G && R>=B -> red; else G>=B -> green; else blue.
//    Accumulate per-class count (15b) and per-class sum of that max channel (22b).
//  - Image class: largest count; ties resolved red > green > blue.
//  - Intensity = floor(sum_class / count_class), 8b. count is never 0 for the winning class.
//  - On the IMG_PIXELS-th pixel: busy=1 next edge; FSM runs a multicycle restoring divider (22 iterations).
//    Inserts {class, intensity, index} into a sorted list of IMAGE_NUM entries; then busy=0.
//    Pixel counter wraps to 0 for the next image.
//  - Sort key ascending: class (red<green<blue), then intensity, then image index.
//  - FSM: IDLE/ACCUM -> DIVIDE -> INSERT -> ACCUM (more images) | OUTPUT (after IMAGE_NUM-th image).
//  - OUTPUT: busy held 1; out_valid=1 for exactly IMAGE_NUM consecutive cycles, entries in sorted order.
//    Then DONE: out_valid=0, busy=1, outputs hold last value until reset.
//  - Reset mid-run discards all partial data; the next run starts fresh.
//  - Sums saturate never: widths sized for 255*16384 max.
// CONFIGURATION
//  ISE_INPUT_CHECK_EN defined: simulation-only checks.
//    $display error if image_in_index changes within an image.
//    $display error if an index repeats within a run.
//    $display error if pixel_in contains X/Z when sampled.
//    No effect on outputs or timing.
//  Undefined: checks omitted; synthesizable logic identical.
// TESTING
//  1. All 32 images solid 0xFF0000 except intensity R=8*idx, indices 0..31 in order.
//     -> 32 outputs color 0, image order 0..31.
//  2. Image 5 all 0x101010 (tie) -> red, intensity 16. Image 6 half 0x00FF00, half 0x0000FF -> green (count tie).
//  3. Mixed classes: blue img 0, green img 1, red img 2 (others blue, intensity 200).
//     -> first outputs (0,2), (1,1), then blue entries.
//  4. Two red images with equal intensity, idx 9 and 3 -> 3 precedes 9.
//  5. Busy handshake: verify no pixel lost or duplicated across each busy window.
//     Exactly 32*16384 samples taken; out_valid high 32 consecutive cycles.
//  6. Assert reset during image 2 accumulation, restart stream -> results match a clean run.

Source files
------------

// File: rtl/ise_image_sorter.sv
// Image sorting engine: classifies streamed RGB images by dominant colour and intensity, then emits them sorted.
// Optional macro ISE_INPUT_CHECK_EN adds simulation-only input-protocol checks with no effect on outputs.
module ise_image_sorter #(
    parameter int unsigned IMAGE_NUM  = 32,
    parameter int unsigned IMG_PIXELS = 16384,
    localparam int unsigned IDX_W     = $clog2(IMAGE_NUM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] image_in_index,
    input  logic [23:0]      pixel_in,
    output logic             busy,
    output logic             out_valid,
    output logic [1:0]       color_index,
    output logic [IDX_W-1:0] image_out_index
);

    localparam int unsigned CNT_W = $clog2(IMG_PIXELS + 1);
    localparam int unsigned SUM_W = $clog2(255 * IMG_PIXELS + 1);
    localparam int unsigned PIX_W = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
    localparam int unsigned IT_W  = $clog2(SUM_W);
    localparam int unsigned KEY_W = 2 + 8 + IDX_W;

    typedef enum logic [2:0] {
        S_ACCUM,
        S_DIVIDE,
        S_INSERT,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_valid;
    logic [1:0]         r_color;
    logic [IDX_W-1:0]   r_oidx;
    logic [PIX_W-1:0]   r_pix;
    logic [CNT_W-1:0]   r_cnt_r, r_cnt_g, r_cnt_b;
    logic [SUM_W-1:0]   r_sum_r, r_sum_g, r_sum_b;
    logic [1:0]         r_cls;
    logic [IDX_W-1:0]   r_cur_idx;
    logic [SUM_W-1:0]   r_quo;
    logic [CNT_W-1:0]   r_rem;
    logic [CNT_W-1:0]   r_div;
    logic [IT_W-1:0]    r_it;
    logic [IDX_W:0]     r_n;
    logic [IDX_W-1:0]   r_optr;
    logic [KEY_W-1:0]   r_list [IMAGE_NUM];

    logic [7:0]         w_r, w_g, w_b, w_pmax;
    logic [1:0]         w_pcls;
    logic [CNT_W-1:0]   w_cnt_r_nxt, w_cnt_g_nxt, w_cnt_b_nxt, w_win_cnt;
    logic [SUM_W-1:0]   w_sum_r_nxt, w_sum_g_nxt, w_sum_b_nxt, w_win_sum;
    logic [1:0]         w_win_cls;
    logic [CNT_W:0]     w_shift;
    logic [CNT_W-1:0]   w_sub;
    logic [KEY_W-1:0]   w_key;
    logic [IMAGE_NUM-1:0] w_lt;
    logic [KEY_W-1:0]   w_ins [IMAGE_NUM];

    assign busy            = r_busy;
    assign out_valid       = r_valid;
    assign color_index     = r_color;
    assign image_out_index = r_oidx;

    assign w_r = pixel_in[23:16];
    assign w_g = pixel_in[15:8];
    assign w_b = pixel_in[7:0];

    always_comb begin
        w_pcls = 2'd2;
        w_pmax = w_b;
        if (w_r >= w_g && w_r >= w_b) begin
            w_pcls = 2'd0;
            w_pmax = w_r;
        end else if (w_g >= w_b) begin
            w_pcls = 2'd1;
            w_pmax = w_g;
        end
    end

    // Next-state sums include the pixel being sampled so the last pixel counts toward the winner.
    assign w_cnt_r_nxt = r_cnt_r + CNT_W'(w_pcls == 2'd0);
    assign w_cnt_g_nxt = r_cnt_g + CNT_W'(w_pcls == 2'd1);
    assign w_cnt_b_nxt = r_cnt_b + CNT_W'(w_pcls == 2'd2);
    assign w_sum_r_nxt = r_sum_r + ((w_pcls == 2'd0) ? SUM_W'(w_pmax) : '0);
    assign w_sum_g_nxt = r_sum_g + ((w_pcls == 2'd1) ? SUM_W'(w_pmax) : '0);
    assign w_sum_b_nxt = r_sum_b + ((w_pcls == 2'd2) ? SUM_W'(w_pmax) : '0);

    always_comb begin
        w_win_cls = 2'd2;
        w_win_cnt = w_cnt_b_nxt;
        w_win_sum = w_sum_b_nxt;
        if (w_cnt_r_nxt >= w_cnt_g_nxt && w_cnt_r_nxt >= w_cnt_b_nxt) begin
            w_win_cls = 2'd0;
            w_win_cnt = w_cnt_r_nxt;
            w_win_sum = w_sum_r_nxt;
        end else if (w_cnt_g_nxt >= w_cnt_b_nxt) begin
            w_win_cls = 2'd1;
            w_win_cnt = w_cnt_g_nxt;
            w_win_sum = w_sum_g_nxt;
        end
    end

    // Restoring division step: dividend bits shift out of r_quo MSB while quotient bits enter at LSB.
    assign w_shift = {r_rem, r_quo[SUM_W-1]};
    assign w_sub   = w_shift[CNT_W-1:0] - r_div;

    assign w_key = {r_cls, r_quo[7:0], r_cur_idx};

    always_comb begin
        w_lt = '0;
        for (int unsigned j = 0; j < IMAGE_NUM; j++) begin
            w_lt[j] = ((IDX_W+1)'(j) < r_n) && (r_list[j] < w_key);
        end
        for (int unsigned j = 0; j < IMAGE_NUM; j++) begin
            w_ins[j] = r_list[j];
            if (!w_lt[j]) begin
                if (j == 0) begin
                    w_ins[j] = w_key;
                end else if (w_lt[j-1]) begin
                    w_ins[j] = w_key;
                end else begin
                    w_ins[j] = r_list[j-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_ACCUM;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_color   <= '0;
            r_oidx    <= '0;
            r_pix     <= '0;
            r_cnt_r   <= '0;
            r_cnt_g   <= '0;
            r_cnt_b   <= '0;
            r_sum_r   <= '0;
            r_sum_g   <= '0;
            r_sum_b   <= '0;
            r_cls     <= '0;
            r_cur_idx <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_it      <= '0;
            r_n       <= '0;
            r_optr    <= '0;
            for (int unsigned j = 0; j < IMAGE_NUM; j++) begin
                r_list[j] <= '0;
            end
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (!r_busy) begin
                        if (r_pix == PIX_W'(IMG_PIXELS - 1)) begin
                            r_pix     <= '0;
                            r_cnt_r   <= '0;
                            r_cnt_g   <= '0;
                            r_cnt_b   <= '0;
                            r_sum_r   <= '0;
                            r_sum_g   <= '0;
                            r_sum_b   <= '0;
                            r_cls     <= w_win_cls;
                            r_quo     <= w_win_sum;
                            r_div     <= w_win_cnt;
                            r_rem     <= '0;
                            r_it      <= '0;
                            r_cur_idx <= image_in_index;
                            r_busy    <= 1'b1;
                            r_state   <= S_DIVIDE;
                        end else begin
                            r_pix   <= r_pix + 1'b1;
                            r_cnt_r <= w_cnt_r_nxt;
                            r_cnt_g <= w_cnt_g_nxt;
                            r_cnt_b <= w_cnt_b_nxt;
                            r_sum_r <= w_sum_r_nxt;
                            r_sum_g <= w_sum_g_nxt;
                            r_sum_b <= w_sum_b_nxt;
                        end
                    end
                end
                S_DIVIDE: begin
                    if (w_shift >= {1'b0, r_div}) begin
                        r_rem <= w_sub;
                        r_quo <= {r_quo[SUM_W-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[CNT_W-1:0];
                        r_quo <= {r_quo[SUM_W-2:0], 1'b0};
                    end
                    r_it <= r_it + 1'b1;
                    if (r_it == IT_W'(SUM_W - 1)) begin
                        r_state <= S_INSERT;
                    end
                end
                S_INSERT: begin
                    for (int unsigned j = 0; j < IMAGE_NUM; j++) begin
                        r_list[j] <= w_ins[j];
                    end
                    r_n <= r_n + 1'b1;
                    if (r_n == (IDX_W+1)'(IMAGE_NUM - 1)) begin
                        r_optr  <= '0;
                        r_state <= S_OUTPUT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_ACCUM;
                    end
                end
                S_OUTPUT: begin
                    r_valid <= 1'b1;
                    r_color <= r_list[r_optr][KEY_W-1 -: 2];
                    r_oidx  <= r_list[r_optr][IDX_W-1:0];
                    r_optr  <= r_optr + 1'b1;
                    if (r_optr == IDX_W'(IMAGE_NUM - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_ACCUM;
                end
            endcase
        end
    end

`ifdef ISE_INPUT_CHECK_EN
    logic [IMAGE_NUM-1:0] r_chk_seen;
    logic [IDX_W-1:0]     r_chk_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chk_seen <= '0;
            r_chk_idx  <= '0;
        end else if (!r_busy && r_state == S_ACCUM) begin
            if ($isunknown(pixel_in)) begin
                $display("ise_image_sorter input check: pixel_in has X/Z at %0t", $time);
            end
            if (r_pix != '0 && image_in_index != r_chk_idx) begin
                $display("ise_image_sorter input check: index changed within image at %0t", $time);
            end
            if (r_pix == '0) begin
                if (r_chk_seen[image_in_index]) begin
                    $display("ise_image_sorter input check: index %0d repeated at %0t", image_in_index, $time);
                end
                r_chk_seen[image_in_index] <= 1'b1;
            end
            r_chk_idx <= image_in_index;
        end
    end
`else
`endif

endmodule

// File: tb/tb_ise_image_sorter.sv
// Testbench for ise_image_sorter: directed and randomized image streams checked against a sorting reference model.
module tb_ise_image_sorter;

    localparam int unsigned IMAGE_NUM  = 32;
    localparam int unsigned IMG_PIXELS = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  image_in_index = '0;
    logic [23:0] pixel_in = '0;
    logic        busy;
    logic        out_valid;
    logic [1:0]  color_index;
    logic [4:0]  image_out_index;

    ise_image_sorter #(
        .IMAGE_NUM (IMAGE_NUM),
        .IMG_PIXELS(IMG_PIXELS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .image_in_index (image_in_index),
        .pixel_in       (pixel_in),
        .busy           (busy),
        .out_valid      (out_valid),
        .color_index    (color_index),
        .image_out_index(image_out_index)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int unsigned cyc = 0;

    int unsigned pix [IMAGE_NUM][IMG_PIXELS];
    int          order [IMAGE_NUM];
    int          exp_col [IMAGE_NUM];
    int          exp_idx [IMAGE_NUM];
    int          q_col[$];
    int          q_idx[$];
    int unsigned q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            q_col.push_back(int'(color_index));
            q_idx.push_back(int'(image_out_index));
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: classify each pixel, pick majority class, average, then sort by composite key.
    task automatic build_model();
        int keys [IMAGE_NUM];
        int cnt [3];
        int sum [3];
        int r, g, b, c, m, win, tmp;
        for (int i = 0; i < IMAGE_NUM; i++) begin
            cnt = '{0, 0, 0};
            sum = '{0, 0, 0};
            for (int p = 0; p < IMG_PIXELS; p++) begin
                r = int'((pix[i][p] >> 16) & 255);
                g = int'((pix[i][p] >> 8) & 255);
                b = int'(pix[i][p] & 255);
                if (r >= g && r >= b) begin c = 0; m = r; end
                else if (g >= b) begin c = 1; m = g; end
                else begin c = 2; m = b; end
                cnt[c] += 1;
                sum[c] += m;
            end
            if (cnt[0] >= cnt[1] && cnt[0] >= cnt[2]) win = 0;
            else if (cnt[1] >= cnt[2]) win = 1;
            else win = 2;
            keys[i] = win * 8192 + (sum[win] / cnt[win]) * 32 + i;
        end
        for (int i = 0; i < IMAGE_NUM; i++)
            for (int j = 0; j < IMAGE_NUM - 1 - i; j++)
                if (keys[j] > keys[j+1]) begin
                    tmp = keys[j]; keys[j] = keys[j+1]; keys[j+1] = tmp;
                end
        for (int i = 0; i < IMAGE_NUM; i++) begin
            exp_col[i] = keys[i] / 8192;
            exp_idx[i] = keys[i] % 32;
        end
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1;
        pixel_in = '0;
        image_in_index = '0;
        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_color", {30'b0, color_index}, 32'd0);
        chk("rst_index", {27'b0, image_out_index}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic fill_random();
        int unsigned base;
        for (int i = 0; i < IMAGE_NUM; i++) begin
            base = $urandom & 24'hFFFFFF;
            for (int p = 0; p < IMG_PIXELS; p++)
                pix[i][p] = ($urandom_range(0, 1) == 0) ? base : ($urandom & 24'hFFFFFF);
        end
    endtask

    task automatic order_linear();
        for (int i = 0; i < IMAGE_NUM; i++) order[i] = i;
    endtask

    task automatic order_shuffle();
        int j, t;
        order_linear();
        for (int i = IMAGE_NUM - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
    endtask

    // Source holds each pixel until an edge where busy was low; abort_at < 0 streams the full run.
    task automatic drive_run(input int abort_at);
        int acc;
        int img;
        int waitc;
        bit b;
        acc = 0;
        for (int k = 0; k < IMAGE_NUM; k++) begin
            img = order[k];
            for (int p = 0; p < IMG_PIXELS; p++) begin
                if (acc == abort_at) return;
                image_in_index = 5'(img);
                pixel_in = 24'(pix[img][p]);
                waitc = 0;
                do begin
                    b = busy;
                    @(posedge clk);
                    #1;
                    waitc++;
                end while (b && waitc < 100);
                if (b) begin
                    chk("busy_timeout", {31'b0, busy}, 32'd0);
                    return;
                end
                acc++;
                if (p == IMG_PIXELS - 1) chk("busy_after_image", {31'b0, busy}, 32'd1);
                else chk("busy_in_image", {31'b0, busy}, 32'd0);
            end
        end
    endtask

    task automatic run_and_check(input string tag);
        int n;
        q_col.delete();
        q_idx.delete();
        q_cyc.delete();
        build_model();
        drive_run(-1);
        for (int c = 0; c < 1000 && q_col.size() < IMAGE_NUM; c++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_nout"}, q_col.size(), IMAGE_NUM);
        n = (q_col.size() < IMAGE_NUM) ? q_col.size() : IMAGE_NUM;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_color"}, q_col[i], exp_col[i]);
            chk({tag, "_index"}, q_idx[i], exp_idx[i]);
            if (i > 0) chk({tag, "_consecutive"}, q_cyc[i] - q_cyc[i-1], 1);
        end
        chk({tag, "_done_busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "_done_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_hold_color"}, {30'b0, color_index}, exp_col[IMAGE_NUM-1]);
        chk({tag, "_hold_index"}, {27'b0, image_out_index}, exp_idx[IMAGE_NUM-1]);
    endtask

    function automatic int find_pos(input int img);
        for (int i = 0; i < q_idx.size(); i++)
            if (q_idx[i] == img) return i;
        return -1;
    endfunction

    initial begin
        int p5, p6, p3, p9;

        // Solid red ramp in index order.
        do_reset();
        for (int i = 0; i < IMAGE_NUM; i++)
            for (int p = 0; p < IMG_PIXELS; p++) pix[i][p] = (8 * i) << 16;
        order_linear();
        run_and_check("t1");
        for (int i = 0; i < IMAGE_NUM && i < q_col.size(); i++) begin
            chk("t1_red", q_col[i], 0);
            chk("t1_order", q_idx[i], i);
        end

        // Grey tie goes red; equal green/blue count goes green.
        do_reset();
        fill_random();
        for (int p = 0; p < IMG_PIXELS; p++) begin
            pix[5][p] = 24'h101010;
            pix[6][p] = (p < IMG_PIXELS / 2) ? 24'h00FF00 : 24'h0000FF;
        end
        order_shuffle();
        run_and_check("t2");
        p5 = find_pos(5);
        p6 = find_pos(6);
        chk("t2_img5_red", (p5 >= 0) ? q_col[p5] : -1, 0);
        chk("t2_img6_green", (p6 >= 0) ? q_col[p6] : -1, 1);

        // Mixed classes.
        do_reset();
        for (int i = 0; i < IMAGE_NUM; i++)
            for (int p = 0; p < IMG_PIXELS; p++) pix[i][p] = 24'h0000C8;
        for (int p = 0; p < IMG_PIXELS; p++) begin
            pix[0][p] = 24'h000050;
            pix[1][p] = 24'h003000;
            pix[2][p] = 24'hE00000;
        end
        order_linear();
        run_and_check("t3");
        if (q_col.size() >= 3) begin
            chk("t3_first", q_col[0] * 32 + q_idx[0], 0 * 32 + 2);
            chk("t3_second", q_col[1] * 32 + q_idx[1], 1 * 32 + 1);
            chk("t3_third", q_col[2] * 32 + q_idx[2], 2 * 32 + 0);
        end

        // Equal red intensity broken by image index.
        do_reset();
        fill_random();
        for (int p = 0; p < IMG_PIXELS; p++) begin
            pix[9][p] = 24'h400000;
            pix[3][p] = 24'h400000;
        end
        order_shuffle();
        run_and_check("t4");
        p3 = find_pos(3);
        p9 = find_pos(9);
        chk("t4_3_before_9", (p3 >= 0 && p9 >= 0 && p3 < p9) ? 1 : 0, 1);

        // Reset during the third image, then a clean restart of the same stream.
        do_reset();
        fill_random();
        order_shuffle();
        drive_run(2 * IMG_PIXELS + 5);
        do_reset();
        run_and_check("t6");

        // Fully randomized runs.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            fill_random();
            order_shuffle();
            run_and_check("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
